// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ requesters and streams
// the captured word LSB byte first. Define UART_TX_ARB_HEADER_EN to prefix each transfer with {4'hA, id}.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int BYTES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*8*BYTES-1:0] req_data,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data
);
    localparam int W     = 8 * BYTES;
    localparam int ID_W  = $clog2(N_REQ);
    localparam int IDX_W = 3;
`ifdef UART_TX_ARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1 + HDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     word_q, word_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic [W-1:0]     req_word [N_REQ];
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*W +: W];
        end
    endgenerate

    // Byte n of a transfer: the header (when enabled) comes first, then the word LSB first.
    function automatic logic [7:0] byte_sel(input logic [W-1:0] w, input logic [7:0] hdr, input int n);
        logic [7:0] r;
        r = 8'h00;
        if (HDR != 0 && n == 0) begin
            r = hdr;
        end else begin
            for (int b = 0; b < BYTES; b++) begin
                if (b == n - HDR) r = w[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // Search starts just after the last winner and wraps, so a held request waits its turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        last_d     = last_q;
        idx_d      = idx_q;
        grant_d    = '0;
        busy_d     = busy_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    word_d           = req_word[win_id];
                    last_d           = win_id;
                    idx_d            = '0;
                    grant_d[win_id]  = 1'b1;
                    busy_d           = 1'b1;
                    tx_start_d       = 1'b1;
                    tx_data_d        = byte_sel(req_word[win_id], {4'hA, 4'(win_id)}, 0);
                    state_d          = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        // last_q holds the id of the transfer in flight.
                        idx_d      = idx_q + 1'b1;
                        tx_start_d = 1'b1;
                        tx_data_d  = byte_sel(word_q, {4'hA, 4'(last_q)}, int'(idx_q) + 1);
                        state_d    = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            last_q     <= ID_W'(N_REQ - 1);
            idx_q      <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a UART model answers each tx_start with a delayed busy
// pulse, and a monitor logs every launched byte with its grant and cycle number.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic        busy;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] log_data [$];
    logic [3:0] log_grant [$];
    int         log_cyc [$];

    bit bfm_en    = 1'b0;
    int bfm_delay = 0;
    int bfm_len   = 2;
    int bfm_phase = 0;
    int bfm_cnt   = 0;

    uart_tx_arbiter #(.N_REQ(4), .BYTES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .busy     (busy),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy rises bfm_delay cycles after tx_start and stays high bfm_len cycles.
    always @(negedge clk) begin
        if (bfm_en) begin
            if (bfm_phase == 0) begin
                if (tx_start) begin
                    if (bfm_delay == 0) begin
                        tx_busy = 1'b1; bfm_cnt = bfm_len; bfm_phase = 2;
                    end else begin
                        bfm_cnt = bfm_delay; bfm_phase = 1;
                    end
                end
            end else if (bfm_phase == 1) begin
                bfm_cnt--;
                if (bfm_cnt == 0) begin
                    tx_busy = 1'b1; bfm_cnt = bfm_len; bfm_phase = 2;
                end
            end else begin
                bfm_cnt--;
                if (bfm_cnt == 0) begin
                    tx_busy = 1'b0; bfm_phase = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (tx_start) begin
            log_data.push_back(tx_data);
            log_grant.push_back(grant);
            log_cyc.push_back(cyc);
            $display("tx byte=%02h grant=%b cycle=%0d", tx_data, grant, cyc);
        end
    end

    task automatic clear_log();
        log_data.delete(); log_grant.delete(); log_cyc.delete();
    endtask

    task automatic set_word(input int i, input logic [15:0] w);
        req_data[i*16 +: 16] = w;
    endtask

    task automatic pulse_reset();
        bfm_en = 1'b0; bfm_phase = 0; tx_busy = 1'b0; req = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int t = 0;
        while (log_data.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        total++;
        if (log_data.size() < n) begin
            bad++;
            $display("FAIL %s timeout: bytes=%0d required=%0d", tag, log_data.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle timeout: busy=%b required=0", tag, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({tx_start, tx_data, grant, busy} !== 14'h0) begin
            bad++;
            $display("FAIL reset_held: start=%b data=%02h grant=%b busy=%b required all 0", tx_start, tx_data, grant, busy);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tx_busy = ~tx_busy;
            @(negedge clk);
            total++;
            if ({tx_start, tx_data, grant, busy} !== 14'h0) begin
                bad++;
                $display("FAIL reset_idle c%0d: start=%b data=%02h grant=%b busy=%b required all 0", c, tx_start, tx_data, grant, busy);
            end
        end
        tx_busy = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        pulse_reset();
        bfm_delay = 0; bfm_len = 2; bfm_en = 1'b1;
        set_word(2, 16'hBEEF);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        total++;
        if (tx_start !== 1'b1 || grant !== 4'b0100 || tx_data !== 8'hEF || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_first: start=%b grant=%b data=%02h busy=%b required 1 0100 ef 1", tx_start, grant, tx_data, busy);
        end
        wait_bytes(2, 100, "single");
        repeat (10) @(negedge clk);
        total++;
        if (log_data.size() != 2 || log_data[0] !== 8'hEF || log_data[1] !== 8'hBE) begin
            bad++;
            $display("FAIL single_bytes: n=%0d b0=%02h b1=%02h required 2 ef be", log_data.size(), log_data[0], log_data[1]);
        end
        total++;
        if (log_grant[1] !== 4'b0000) begin
            bad++;
            $display("FAIL single_grant2: grant=%b required 0000", log_grant[1]);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_end: busy=%b required 0", busy);
        end
        $display("test_single done");
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int         exp_id [5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        for (int i = 0; i < 4; i++) set_word(i, {8'hB0 + 8'(i), 8'hA0 + 8'(i)});
        bfm_delay = 0; bfm_len = 5; bfm_en = 1'b1;
        req = 4'b1111;
        wait_bytes(10, 400, "contention");
        req = 4'b0000;
        wait_idle(100, "contention");
        for (int t = 0; t < 5; t++) begin
            total++;
            if (log_grant[2*t] !== exp_g[t] || log_grant[2*t+1] !== 4'b0000 ||
                log_data[2*t] !== 8'hA0 + 8'(exp_id[t]) || log_data[2*t+1] !== 8'hB0 + 8'(exp_id[t])) begin
                bad++;
                $display("FAIL contention_t%0d: grant=%b data=%02h %02h required %b %02h %02h", t,
                         log_grant[2*t], log_data[2*t], log_data[2*t+1], exp_g[t],
                         8'hA0 + 8'(exp_id[t]), 8'hB0 + 8'(exp_id[t]));
            end
        end
        total++;
        if (log_cyc[1] - log_cyc[0] != 6 || log_cyc[2] - log_cyc[1] != 7) begin
            bad++;
            $display("FAIL contention_gap: intra=%0d inter=%0d required 6 7", log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]);
        end
        $display("test_contention done");
    endtask

    task automatic test_late_busy();
        pulse_reset();
        set_word(1, 16'h5AC3);
        bfm_delay = 3; bfm_len = 2; bfm_en = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        wait_bytes(2, 100, "late_busy");
        repeat (20) @(negedge clk);
        total++;
        if (log_data.size() != 2 || log_data[0] !== 8'hC3 || log_data[1] !== 8'h5A || log_grant[0] !== 4'b0010) begin
            bad++;
            $display("FAIL late_busy: n=%0d b0=%02h b1=%02h g=%b required 2 c3 5a 0010", log_data.size(), log_data[0], log_data[1], log_grant[0]);
        end
        $display("test_late_busy done");
    endtask

    task automatic test_mid_change();
        pulse_reset();
        set_word(3, 16'hC0DE);
        bfm_delay = 0; bfm_len = 3; bfm_en = 1'b1;
        req = 4'b1000;
        wait_bytes(1, 20, "mid_change");
        req = 4'b0000;
        set_word(3, 16'hFFFF);
        wait_bytes(2, 100, "mid_change");
        wait_idle(50, "mid_change");
        total++;
        if (log_data.size() != 2 || log_data[0] !== 8'hDE || log_data[1] !== 8'hC0) begin
            bad++;
            $display("FAIL mid_change: n=%0d b0=%02h b1=%02h required 2 de c0", log_data.size(), log_data[0], log_data[1]);
        end
        $display("test_mid_change done");
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        set_word(0, 16'h7788);
        bfm_delay = 0; bfm_len = 6; bfm_en = 1'b1;
        req = 4'b0001;
        wait_bytes(1, 20, "mid_reset");
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({tx_start, tx_data, grant, busy} !== 14'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs: start=%b data=%02h grant=%b busy=%b required all 0", tx_start, tx_data, grant, busy);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (log_data.size() != 1 || log_data[0] !== 8'h88) begin
            bad++;
            $display("FAIL mid_reset_no_byte1: n=%0d b0=%02h required 1 88", log_data.size(), log_data[0]);
        end
        $display("test_mid_reset done");
    endtask

`ifdef UART_TX_ARB_HEADER_EN
    task automatic test_header();
        pulse_reset();
        set_word(3, 16'h1234);
        bfm_delay = 0; bfm_len = 2; bfm_en = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        wait_bytes(3, 100, "header");
        repeat (10) @(negedge clk);
        total++;
        if (log_data.size() != 3 || log_data[0] !== 8'hA3 || log_data[1] !== 8'h34 || log_data[2] !== 8'h12 ||
            log_grant[0] !== 4'b1000 || log_grant[1] !== 4'b0000) begin
            bad++;
            $display("FAIL header: n=%0d bytes=%02h %02h %02h g=%b required 3 a3 34 12 1000",
                     log_data.size(), log_data[0], log_data[1], log_data[2], log_grant[0]);
        end
        $display("test_header done");
    endtask
`endif

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        test_reset();
`ifdef UART_TX_ARB_HEADER_EN
        test_header();
`else
        test_single();
        test_contention();
        test_late_busy();
        test_mid_change();
        test_mid_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
